mac_acc_stage: RTL and testbench

- Accumulator stage of the 16-bit MAC, directly downstream of the 16x16 signed multiplier.
- Consumes one 32-bit signed product per cycle and accumulates it into a 40-bit accumulator (8 guard bits).
- The accumulate add is split at bit 20 into a two-stage carry-pipelined add built from 4-bit carry-select slices. This gives full throughput with no feedback critical path across the full width.
- Delivers one result per accumulation group through a valid/ready output.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/csel_add_n.sv | 44 ++++
 rtl/mac_acc_stage.sv | 124 ++++++++++++
 tb/tb_mac_acc_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared widths and helpers for the MAC accumulator stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int PROD_W    = 32;
    localparam int GUARD_W   = 8;
    localparam int ACC_W     = PROD_W + GUARD_W;
    localparam int SPLIT     = 20;
    localparam int HI_W      = ACC_W - SPLIT;
    localparam int SLICES_LO = SPLIT / 4;
    localparam int SLICES_HI = HI_W / 4;

    // Sign-extend the upper product bits to the full high-accumulator width.
    function automatic logic [HI_W-1:0] sext_hi(input logic [PROD_W-SPLIT-1:0] p_hi);
        return {{GUARD_W{p_hi[PROD_W-SPLIT-1]}}, p_hi};
    endfunction

endpackage

`default_nettype wire

// File: rtl/csel_add_n.sv
// ============================================================================
// Module      : csel_add_n
// Description : N-bit adder built as a ripple of 4-bit carry-select slices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csel_add_n #(
    parameter int N = 20
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    localparam int SLICES = N / 4;

    logic [SLICES:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < SLICES; i++) begin : g_slice
            logic [4:0] w_s0;
            logic [4:0] w_s1;

            assign w_s0 = {1'b0, a[4*i+3 -: 4]} + {1'b0, b[4*i+3 -: 4]};
            assign w_s1 = {1'b0, a[4*i+3 -: 4]} + {1'b0, b[4*i+3 -: 4]} + 5'd1;

            assign sum[4*i+3 -: 4] = w_c[i] ? w_s1[3:0] : w_s0[3:0];
            assign w_c[i+1]        = w_c[i] ? w_s1[4]   : w_s0[4];
        end
    endgenerate

    assign cout  = w_c[SLICES];
    // Sum bit = a ^ b ^ carry-in at that bit, so the MSB carry-in falls out directly.
    assign c_msb = a[N-1] ^ b[N-1] ^ sum[N-1];

endmodule

`default_nettype wire

// File: rtl/mac_acc_stage.sv
// ============================================================================
// Module      : mac_acc_stage
// Description : 40-bit MAC accumulator, two-stage carry-pipelined add split
//               at SPLIT, one result per group via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc_stage
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    logic             w_adv;

    // Stage A: low half accumulator and forwarded high operand
    logic [SPLIT-1:0] r_lo_acc;
    logic             r_ca;
    logic [HI_W-1:0]  r_hi_op;
    logic             r_a_first;
    logic             r_a_last;
    logic             r_a_valid;

    // Stage B: high half accumulator and registered result
    logic [HI_W-1:0]  r_hi_acc;
    logic [SPLIT-1:0] r_b_lo;
    logic             r_ovf;
    logic             r_b_valid;
    logic             r_b_last;

    logic [SPLIT-1:0] w_lo_base;
    logic [SPLIT-1:0] w_lo_sum;
    logic             w_lo_cout;
    logic             w_unused_lo_cmsb;

    logic [HI_W-1:0]  w_hi_base;
    logic [HI_W-1:0]  w_hi_sum;
    logic             w_hi_cout;
    logic             w_hi_cmsb;

    assign out_valid = r_b_valid && r_b_last;
    assign w_adv     = !(out_valid && !out_ready);
    assign in_ready  = w_adv;

    assign w_lo_base = in_first  ? '0 : r_lo_acc;
    assign w_hi_base = r_a_first ? '0 : r_hi_acc;

    csel_add_n #(.N(SPLIT)) u_add_lo (
        .a     (w_lo_base),
        .b     (in_prod[SPLIT-1:0]),
        .cin   (1'b0),
        .sum   (w_lo_sum),
        .cout  (w_lo_cout),
        .c_msb (w_unused_lo_cmsb)
    );

    csel_add_n #(.N(HI_W)) u_add_hi (
        .a     (w_hi_base),
        .b     (r_hi_op),
        .cin   (r_ca),
        .sum   (w_hi_sum),
        .cout  (w_hi_cout),
        .c_msb (w_hi_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_acc  <= '0;
            r_ca      <= 1'b0;
            r_hi_op   <= '0;
            r_a_first <= 1'b0;
            r_a_last  <= 1'b0;
            r_a_valid <= 1'b0;
        end else if (w_adv) begin
            if (in_valid) begin
                r_lo_acc  <= w_lo_sum;
                r_ca      <= w_lo_cout;
                r_hi_op   <= sext_hi(in_prod[PROD_W-1:SPLIT]);
                r_a_first <= in_first;
                r_a_last  <= in_last;
                r_a_valid <= 1'b1;
            end else begin
                r_a_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_acc  <= '0;
            r_b_lo    <= '0;
            r_ovf     <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_last  <= 1'b0;
        end else if (w_adv) begin
            if (r_a_valid) begin
                r_hi_acc  <= w_hi_sum;
                r_b_lo    <= r_lo_acc;
                r_ovf     <= (r_a_first ? 1'b0 : r_ovf) | (w_hi_cmsb ^ w_hi_cout);
                r_b_valid <= 1'b1;
                r_b_last  <= r_a_last;
            end else begin
                r_b_valid <= 1'b0;
            end
        end
    end

    assign out_acc = {r_hi_acc, r_b_lo};
    assign out_ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_acc_stage.sv
// ============================================================================
// Module      : tb_mac_acc_stage
// Description : Scoreboard bench for mac_acc_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_acc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_prod;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_acc;
    logic        out_ovf;

    typedef struct {
        logic [39:0] acc;
        logic        ovf;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    mac_acc_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is handed over.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got out_acc=0x%0h, required no output", out_acc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check1("out_acc", out_acc, e.acc);
                check1("out_ovf", {39'd0, out_ovf}, {39'd0, e.ovf});
                if (e.chk_lat)
                    check1("latency_cycle", 40'(cyc), 40'(e.cyc));
            end
        end
    end

    task automatic beat(input logic [31:0] p, input logic f, input logic l,
                        input logic [39:0] eacc, input logic eovf, input bit chk);
        int n;
        in_valid = 1'b1;
        in_prod  = p;
        in_first = f;
        in_last  = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        if (l) begin
            exp_t e;
            e.acc     = eacc;
            e.ovf     = eovf;
            e.cyc     = cyc + 1;
            e.chk_lat = chk;
            q.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        check1("rst_out_valid", {39'd0, out_valid}, 40'd0);
        check1("rst_out_acc", out_acc, 40'd0);
        check1("rst_out_ovf", {39'd0, out_ovf}, 40'd0);
        check1("rst_in_ready", {39'd0, in_ready}, 40'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single beat group and latency
        beat(32'h0000_0005, 1, 1, 40'h00_0000_0005, 1'b0, 1);
        idle(2);

        // Three max-positive beats
        beat(32'h7FFF_FFFF, 1, 0, '0, 1'b0, 0);
        beat(32'h7FFF_FFFF, 0, 0, '0, 1'b0, 0);
        beat(32'h7FFF_FFFF, 0, 1, 40'h01_7FFF_FFFD, 1'b0, 1);
        idle(2);

        // Carry across the split, then signed case with a bubble inside
        beat(32'h000F_FFFF, 1, 0, '0, 1'b0, 0);
        beat(32'h0000_0001, 0, 1, 40'h00_0010_0000, 1'b0, 1);
        beat(32'h0000_0003, 1, 0, '0, 1'b0, 0);
        idle(3);
        beat(32'hFFFF_FFFB, 0, 1, 40'hFF_FFFF_FFFE, 1'b0, 1);
        idle(2);

        // Signed overflow over 257 most-negative beats, then a clean group
        for (int i = 0; i < 257; i++)
            beat(32'h8000_0000, (i == 0), (i == 256), 40'h7F_8000_0000, 1'b1, 1);
        beat(32'h0000_0001, 1, 1, 40'h00_0000_0001, 1'b0, 1);
        idle(2);

        // Back-to-back groups, results on consecutive cycles
        beat(32'h0000_0001, 1, 0, '0, 1'b0, 0);
        beat(32'h0000_0002, 0, 1, 40'h00_0000_0003, 1'b0, 1);
        beat(32'h0000_0003, 1, 1, 40'h00_0000_0003, 1'b0, 1);
        idle(2);

        // Backpressure: hold out_ready low for 4 cycles with beats queued
        out_ready = 1'b0;
        fork
            begin
                beat(32'h0000_0009, 1, 1, 40'h00_0000_0009, 1'b0, 0);
                beat(32'h0000_000A, 1, 1, 40'h00_0000_000A, 1'b0, 0);
                beat(32'h0000_000B, 1, 0, '0, 1'b0, 0);
                beat(32'h0000_000C, 0, 1, 40'h00_0000_0017, 1'b0, 0);
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                check1("bp_out_valid", {39'd0, out_valid}, 40'd1);
                repeat (4) begin
                    @(negedge clk);
                    check1("bp_in_ready", {39'd0, in_ready}, 40'd0);
                    check1("bp_out_acc_hold", out_acc, 40'h00_0000_0009);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Reset mid-group discards partial state
        beat(32'h0000_0001, 1, 0, '0, 1'b0, 0);
        beat(32'h0000_0002, 0, 0, '0, 1'b0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check1("midrst_out_valid", {39'd0, out_valid}, 40'd0);
        check1("midrst_in_ready", {39'd0, in_ready}, 40'd1);
        check1("midrst_out_acc", out_acc, 40'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        beat(32'h0000_0007, 0, 1, 40'h00_0000_0007, 1'b0, 1);
        beat(32'h0000_0007, 1, 1, 40'h00_0000_0007, 1'b0, 1);
        beat(32'h0000_0002, 0, 1, 40'h00_0000_0009, 1'b0, 1);

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 50) begin
                @(posedge clk);
                n++;
            end
            idle(2);
            if (q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL drain: got %0d results outstanding, required 0", q.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
